// File: rtl/y_chunk_adder_if.sv
// ---------------------------------------------------------------------------
// y_chunk_adder_if
// Handshake bundle for the chunked adder/subtractor.
//   master: operand producer / result consumer side
//     drives in_valid, a, b, cin, sub, out_ready
//     observes in_ready, out_valid, z, cout, ovf, zero
//   slave: the adder itself (mirror directions)
// WIDTH must match the WIDTH of the adder it is bound to.
// ---------------------------------------------------------------------------
interface y_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, z, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, z, cout, ovf, zero
  );
endinterface

// File: rtl/y_chunk_adder.sv
// ---------------------------------------------------------------------------
// y_chunk_adder
// Multi-cycle add/subtract of two WIDTH-bit operands, CHUNK bits per clock,
// least significant chunk first, with one carry flop rippling between cycles.
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - asynchronous active-high reset
//   bus    - y_chunk_adder_if.slave:
//              in_valid/in_ready   operand handshake (ready only when idle)
//              a, b, cin, sub      operands; sub=1 computes a-b, cin ignored
//              out_valid/out_ready result handshake, result held until taken
//              z, cout, ovf, zero  result and flags (cout=1 means no borrow)
// ---------------------------------------------------------------------------
module y_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            reset,
  y_chunk_adder_if.slave  bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("y_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;
  logic [WIDTH-1:0] res_next;

  // Operands are shifted right each RUN cycle, so the active chunk is
  // always the bottom CHUNK bits.
  assign a_chunk   = a_q[CHUNK-1:0];
  assign b_chunk   = b_q[CHUNK-1:0];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  // Carry into the top bit of the chunk recovered from the sum bit:
  // s = a ^ b ^ c  =>  c = s ^ a ^ b. On the last chunk this is the carry
  // into bit WIDTH-1, which the signed overflow flag needs.
  assign msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

  // Sum bits enter the result register from the top; after NCH cycles the
  // first chunk has reached bit 0. Shift form keeps NCH=1 legal.
  assign res_next = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    z_d         = z_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is a + ~b + 1; the +1 rides in on the carry flop.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_next;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Visible outputs change only here, so no partial sum leaks out.
          z_d         = res_next;
          cout_d      = chunk_sum[CHUNK];
          ovf_d       = msb_carry_in ^ chunk_sum[CHUNK];
          zero_d      = (res_next == '0);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      z_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      z_q         <= z_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_y_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_y_chunk_adder
// Five adder configurations share one set of stimulus signals; 'sel' picks
// which one receives in_valid and whose outputs are observed.
//   sel 0: W=8  C=4    sel 1: W=8  C=2
//   sel 2: W=32 C=1    sel 3: W=32 C=8    sel 4: W=32 C=32
// ---------------------------------------------------------------------------
module tb_y_chunk_adder;

  typedef struct packed {
    logic [31:0] z;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  int          sel;
  logic        stall_en;

  logic        m_in_ready;
  logic        m_out_valid;
  logic [31:0] m_z;
  logic        m_cout;
  logic        m_ovf;
  logic        m_zero;

  int tests_run;
  int tests_failed;
  res_t sbq[$];

  y_chunk_adder_if #(.WIDTH(8))  if0 ();
  y_chunk_adder_if #(.WIDTH(8))  if1 ();
  y_chunk_adder_if #(.WIDTH(32)) if2 ();
  y_chunk_adder_if #(.WIDTH(32)) if3 ();
  y_chunk_adder_if #(.WIDTH(32)) if4 ();

  y_chunk_adder #(.WIDTH(8),  .CHUNK(4))  u_w8c4   (.clk(clk), .reset(reset), .bus(if0));
  y_chunk_adder #(.WIDTH(8),  .CHUNK(2))  u_w8c2   (.clk(clk), .reset(reset), .bus(if1));
  y_chunk_adder #(.WIDTH(32), .CHUNK(1))  u_w32c1  (.clk(clk), .reset(reset), .bus(if2));
  y_chunk_adder #(.WIDTH(32), .CHUNK(8))  u_w32c8  (.clk(clk), .reset(reset), .bus(if3));
  y_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_w32c32 (.clk(clk), .reset(reset), .bus(if4));

  assign if0.in_valid = in_valid && (sel == 0);
  assign if1.in_valid = in_valid && (sel == 1);
  assign if2.in_valid = in_valid && (sel == 2);
  assign if3.in_valid = in_valid && (sel == 3);
  assign if4.in_valid = in_valid && (sel == 4);
  assign if0.a = a[7:0];  assign if0.b = b[7:0];
  assign if1.a = a[7:0];  assign if1.b = b[7:0];
  assign if2.a = a;       assign if2.b = b;
  assign if3.a = a;       assign if3.b = b;
  assign if4.a = a;       assign if4.b = b;
  assign if0.cin = cin;   assign if0.sub = sub;   assign if0.out_ready = out_ready;
  assign if1.cin = cin;   assign if1.sub = sub;   assign if1.out_ready = out_ready;
  assign if2.cin = cin;   assign if2.sub = sub;   assign if2.out_ready = out_ready;
  assign if3.cin = cin;   assign if3.sub = sub;   assign if3.out_ready = out_ready;
  assign if4.cin = cin;   assign if4.sub = sub;   assign if4.out_ready = out_ready;

  always_comb begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_z         = '0;
    m_cout      = 1'b0;
    m_ovf       = 1'b0;
    m_zero      = 1'b0;
    case (sel)
      0: begin m_in_ready = if0.in_ready; m_out_valid = if0.out_valid; m_z = {24'b0, if0.z};
               m_cout = if0.cout; m_ovf = if0.ovf; m_zero = if0.zero; end
      1: begin m_in_ready = if1.in_ready; m_out_valid = if1.out_valid; m_z = {24'b0, if1.z};
               m_cout = if1.cout; m_ovf = if1.ovf; m_zero = if1.zero; end
      2: begin m_in_ready = if2.in_ready; m_out_valid = if2.out_valid; m_z = if2.z;
               m_cout = if2.cout; m_ovf = if2.ovf; m_zero = if2.zero; end
      3: begin m_in_ready = if3.in_ready; m_out_valid = if3.out_valid; m_z = if3.z;
               m_cout = if3.cout; m_ovf = if3.ovf; m_zero = if3.zero; end
      4: begin m_in_ready = if4.in_ready; m_out_valid = if4.out_valid; m_z = if4.z;
               m_cout = if4.cout; m_ovf = if4.ovf; m_zero = if4.zero; end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arithmetic: plain wide addition; overflow from operand/result
  // signs rather than from carries.
  function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                 input logic tcin, input logic tsub, input int w);
    logic [63:0] m;
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] s;
    res_t r;
    m    = (64'd1 << w) - 64'd1;
    av   = {32'b0, ta} & m;
    bv   = (tsub ? ~{32'b0, tb_v} : {32'b0, tb_v}) & m;
    s    = av + bv + {63'b0, (tsub ? 1'b1 : tcin)};
    r.z    = s[31:0] & m[31:0];
    r.cout = s[w];
    r.ovf  = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    r.zero = (r.z == 32'b0);
    return r;
  endfunction

  function automatic vec_t mk(input int s, input logic [31:0] va, input logic [31:0] vb,
                              input logic vcin, input logic vsub, input logic [31:0] ez,
                              input logic ec, input logic eo, input logic ezr);
    vec_t v;
    v.sel = s; v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
    v.exp.z = ez; v.exp.cout = ec; v.exp.ovf = eo; v.exp.zero = ezr;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard consumer: every accepted result is compared against the head
  // of the expected queue.
  always @(negedge clk) begin
    if (!reset && m_out_valid && out_ready) begin
      res_t got;
      got = '{z: m_z, cout: m_cout, ovf: m_ovf, zero: m_zero};
      tests_run++;
      if (sbq.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL spurious result sel%0d: got z=%h cout=%b ovf=%b zero=%b, expected none",
                 sel, got.z, got.cout, got.ovf, got.zero);
      end else begin
        res_t e;
        e = sbq.pop_front();
        if (got !== e) begin
          tests_failed++;
          $display("[TB] FAIL result sel%0d: got z=%h cout=%b ovf=%b zero=%b, expected z=%h cout=%b ovf=%b zero=%b",
                   sel, got.z, got.cout, got.ovf, got.zero, e.z, e.cout, e.ovf, e.zero);
        end
      end
    end
  end

  // Random result backpressure, active only when stall_en is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) out_ready = ($urandom_range(3) != 0);
    end
  end

  // Present one operation, wait for acceptance, push its expected result,
  // then scramble the operand lines (they are don't-care after acceptance).
  task automatic apply_stimulus(input logic [31:0] ta, input logic [31:0] tb_v,
                                input logic tcin, input logic tsub, input res_t e);
    int guard;
    guard = 0;
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!m_in_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept timeout sel%0d: got in_ready=0, expected 1", sel);
      in_valid = 1'b0;
      return;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain timeout sel%0d: got %0d pending, expected 0", sel, sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stall_en  = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sel = 0;

    vecs[0]  = mk(0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(0, 32'h05, 32'h05, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1);
    vecs[2]  = mk(0, 32'h03, 32'h05, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(0, 32'h05, 32'h05, 1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1);
    vecs[4]  = mk(1, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
    vecs[5]  = mk(1, 32'hFF, 32'h01, 1'b1, 1'b0, 32'h01, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(2, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    vecs[8]  = mk(3, 32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(4, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    vecs[10] = mk(4, 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of every configuration.
    for (int s = 0; s < 5; s++) begin
      sel = s;
      @(negedge clk);
      check_output($sformatf("reset state sel%0d", s),
                   64'({m_in_ready, m_out_valid, m_z, m_cout, m_ovf, m_zero}),
                   64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}));
    end

    // Directed vectors through the scoreboard.
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      sel = vecs[i].sel;
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
      wait_drain();
    end

    // Latency and backpressure on W=8 C=4.
    sel = 0;
    out_ready = 1'b0;
    apply_stimulus(32'h7F, 32'h01, 1'b0, 1'b0, '{z: 32'h80, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
    @(negedge clk);
    check_output("latency cycle 0", 64'(m_out_valid), 64'(1'b0));
    @(negedge clk);
    check_output("latency cycle 1", 64'(m_out_valid), 64'(1'b0));
    @(negedge clk);
    check_output("latency cycle 2", 64'(m_out_valid), 64'(1'b1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        in_valid = 1'b1; a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0;
      end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
      check_output($sformatf("backpressure hold %0d", i),
                   64'({m_out_valid, m_in_ready, m_z, m_cout, m_ovf, m_zero}),
                   64'({1'b1, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check_output("after handshake",
                 64'({m_in_ready, m_out_valid, m_z, m_cout, m_ovf, m_zero}),
                 64'({1'b1, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output($sformatf("ignored in_valid %0d", i), 64'(m_in_ready), 64'(1'b1));
    end

    // Reset pulse mid-RUN on W=8 C=2 (previous z there is 01).
    sel = 1;
    @(posedge clk);
    #1;
    a = 32'h12; b = 32'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("reset mid-run",
                 64'({m_out_valid, m_in_ready, m_z, m_cout, m_ovf, m_zero}),
                 64'({1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0}));
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(32'h12, 32'h34, 1'b0, 1'b0, '{z: 32'h46, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    @(negedge clk);
    check_output("no partial z", 64'(m_z), 64'h0);
    wait_drain();

    // Random streams with output stalls on the 32-bit configurations.
    stall_en = 1'b1;
    for (int s = 2; s < 5; s++) begin
      int n;
      sel = s;
      n = (s == 2) ? 800 : 2000;
      for (int i = 0; i < n; i++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        rs;
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        if (i % 16 == 0) rb = ~ra;
        if (i % 16 == 1) rb = ra;
        apply_stimulus(ra, rb, rc, rs, model(ra, rb, rc, rs, 32));
      end
      wait_drain();
    end
    stall_en = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
